// File: rtl/stopwatch_lap_timer.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_lap_timer
// Description : Stopwatch control FSM with prescaled tick counter, overflow
//               policy and a show-ahead lap-capture FIFO.
//               Optional feature macro: STOPWATCH_WRAP_EN
//                 defined   -> counter wraps, cnt_ovf is a sticky flag
//                 undefined -> counter saturates, SATURATED state entered
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_lap_timer #(
  parameter int CNT_W     = 16,
  parameter int PRESCALE  = 10,
  parameter int LAP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         reset,
  input  logic                         lap,
  input  logic                         lap_rd,
  output logic [1:0]                   status,
  output logic                         count_en,
  output logic [CNT_W-1:0]             count,
  output logic                         cnt_ovf,
  output logic                         lap_valid,
  output logic [CNT_W-1:0]             lap_data,
  output logic [$clog2(LAP_DEPTH):0]   lap_level,
  output logic                         lap_ovf
);

  // Widths. A prescaler of 1 still gets a 1-bit register that stays at 0.
  localparam int c_pw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int c_aw = $clog2(LAP_DEPTH);
  localparam int c_lw = c_aw + 1;

  localparam logic [c_pw-1:0]  c_presc_last = c_pw'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;
  localparam logic [c_lw-1:0]  c_fifo_full  = c_lw'(LAP_DEPTH);

  // Encoding equals the status output code.
  typedef enum logic [1:0] {
    S_IDLE      = 2'b00,
    S_RUNNING   = 2'b01,
    S_PAUSED    = 2'b10,
    S_SATURATED = 2'b11
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_pw-1:0]   r_presc;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  r_mem [LAP_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_lw-1:0]   r_level;
  logic              r_lap_ovf;

  logic              w_tick;
  logic              w_at_max;
  logic              w_lap_acc;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  // Tick and FIFO handshake qualifiers; the synchronous clear blocks lap traffic.
  always_comb begin
    w_tick    = (r_state == S_RUNNING) && (r_presc == c_presc_last);
    w_at_max  = (r_count == c_cnt_max);
    w_lap_acc = lap && !reset && (r_state != S_IDLE);
    w_full    = (r_level == c_fifo_full);
    w_pop     = lap_rd && (r_level != '0) && !reset;
    w_push    = w_lap_acc && (!w_full || w_pop);
    w_drop    = w_lap_acc && w_full && !w_pop;
  end

  // Next-state logic: reset > stop > start; SATURATED only exits via reset.
  always_comb begin
    w_state_nxt = r_state;
    if (reset) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!stop && start) w_state_nxt = S_RUNNING;
        end
        S_RUNNING: begin
          if (stop) begin
            w_state_nxt = S_PAUSED;
          end
`ifndef STOPWATCH_WRAP_EN
          else if (w_tick && w_at_max) begin
            w_state_nxt = S_SATURATED;
          end
`endif
        end
        S_PAUSED: begin
          if (!stop && start) w_state_nxt = S_RUNNING;
        end
        S_SATURATED: begin
          w_state_nxt = S_SATURATED;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Prescaler: advances only while running, holds when paused, clears in idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (reset) begin
      r_presc <= '0;
    end else begin
      case (r_state)
        S_RUNNING: r_presc <= w_tick ? '0 : r_presc + 1'b1;
        S_IDLE:    r_presc <= '0;
        default:   r_presc <= r_presc;
      endcase
    end
  end

  // Elapsed-tick counter; at the top value it either wraps or holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (reset) begin
      r_count <= '0;
    end else if (w_tick) begin
      if (!w_at_max) begin
        r_count <= r_count + 1'b1;
      end
`ifdef STOPWATCH_WRAP_EN
      else begin
        r_count <= '0;
      end
`endif
    end
  end

`ifdef STOPWATCH_WRAP_EN
  logic r_cnt_ovf;

  // Sticky wrap flag, set on the first wrap and cleared only by a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_cnt_ovf <= 1'b0;
    else if (reset)                r_cnt_ovf <= 1'b0;
    else if (w_tick && w_at_max)   r_cnt_ovf <= 1'b1;
  end

  assign cnt_ovf = r_cnt_ovf;
`else
  assign cnt_ovf = (r_state == S_SATURATED);
`endif

  // Lap storage; not reset because unread slots are masked at the output.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_count;
  end

  // FIFO pointers, fill level and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_lap_ovf <= 1'b0;
    end else if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_lap_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
      if (w_drop) r_lap_ovf <= 1'b1;
    end
  end

  // Output decode, all from registered state.
  always_comb begin
    status    = r_state;
    count_en  = (r_state == S_RUNNING);
    count     = r_count;
    lap_valid = (r_level != '0);
    lap_data  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
    lap_level = r_level;
    lap_ovf   = r_lap_ovf;
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_lap_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_lap_timer
// Description : Self-checking bench for stopwatch_lap_timer with directed
//               scenarios and randomized pulses against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_lap_timer;

  localparam int CNT_W     = 4;
  localparam int PRESCALE  = 3;
  localparam int LAP_DEPTH = 4;
  localparam int c_max     = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUS = 2;
  localparam int M_SAT  = 3;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       start, stop, reset, lap, lap_rd;
  logic [1:0]                 status;
  logic                       count_en;
  logic [CNT_W-1:0]           count;
  logic                       cnt_ovf;
  logic                       lap_valid;
  logic [CNT_W-1:0]           lap_data;
  logic [$clog2(LAP_DEPTH):0] lap_level;
  logic                       lap_ovf;

  stopwatch_lap_timer #(
    .CNT_W     (CNT_W),
    .PRESCALE  (PRESCALE),
    .LAP_DEPTH (LAP_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .reset     (reset),
    .lap       (lap),
    .lap_rd    (lap_rd),
    .status    (status),
    .count_en  (count_en),
    .count     (count),
    .cnt_ovf   (cnt_ovf),
    .lap_valid (lap_valid),
    .lap_data  (lap_data),
    .lap_level (lap_level),
    .lap_ovf   (lap_ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: mode, cycles elapsed in the current tick period,
  // elapsed ticks, captured laps as a queue, and the two flags.
  int m_mode;
  int m_phase;
  int m_count;
  int m_cnt_ovf;
  int m_lap_ovf;
  int m_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_phase   = 0;
    m_count   = 0;
    m_cnt_ovf = 0;
    m_lap_ovf = 0;
    m_q.delete();
  endtask

  // One clock of behaviour, derived from the stopwatch rules.
  task automatic model_step(input bit s, input bit t, input bit r, input bit l, input bit rd);
    bit tick;
    bit was_max;
    bit pop;
    bit full;
    int old_mode;
    if (r) begin
      model_reset();
      return;
    end
    old_mode = m_mode;
    tick     = (old_mode == M_RUN) && (m_phase == PRESCALE - 1);
    was_max  = (m_count == c_max);
    pop      = rd && (m_q.size() > 0);
    full     = (m_q.size() == LAP_DEPTH);
    if (pop) void'(m_q.pop_front());
    if (l && old_mode != M_IDLE) begin
      if (!full || pop) m_q.push_back(m_count);
      else              m_lap_ovf = 1;
    end
    if (tick) begin
      if (!was_max) begin
        m_count = m_count + 1;
      end else begin
`ifdef STOPWATCH_WRAP_EN
        m_count   = 0;
        m_cnt_ovf = 1;
`endif
      end
    end
    if (old_mode == M_RUN)       m_phase = (m_phase + 1) % PRESCALE;
    else if (old_mode == M_IDLE) m_phase = 0;
    case (old_mode)
      M_IDLE, M_PAUS: if (!t && s) m_mode = M_RUN;
      M_RUN: begin
        if (t) m_mode = M_PAUS;
`ifndef STOPWATCH_WRAP_EN
        else if (tick && was_max) m_mode = M_SAT;
`endif
      end
      default: m_mode = old_mode;
    endcase
  endtask

  task automatic compare_all();
    int exp_ovf;
`ifdef STOPWATCH_WRAP_EN
    exp_ovf = m_cnt_ovf;
`else
    exp_ovf = (m_mode == M_SAT) ? 1 : 0;
`endif
    check("status",    32'(status),    m_mode);
    check("count_en",  32'(count_en),  (m_mode == M_RUN) ? 1 : 0);
    check("count",     32'(count),     m_count);
    check("cnt_ovf",   32'(cnt_ovf),   exp_ovf);
    check("lap_valid", 32'(lap_valid), (m_q.size() > 0) ? 1 : 0);
    check("lap_data",  32'(lap_data),  (m_q.size() > 0) ? m_q[0] : 0);
    check("lap_level", 32'(lap_level), m_q.size());
    check("lap_ovf",   32'(lap_ovf),   m_lap_ovf);
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic cycle(input bit s, input bit t, input bit r, input bit l, input bit rd);
    start  = s;
    stop   = t;
    reset  = r;
    lap    = l;
    lap_rd = rd;
    model_step(s, t, r, l, rd);
    @(posedge clk);
    #1;
    start  = 1'b0;
    stop   = 1'b0;
    reset  = 1'b0;
    lap    = 1'b0;
    lap_rd = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic wait_count(input int n);
    for (int i = 0; i < 200 && m_count != n; i++) cycle(0, 0, 0, 0, 0);
    check("wait_count", 32'(count), n);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    reset  = 1'b0;
    lap    = 1'b0;
    lap_rd = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_status",    32'(status),    0);
    check("rst_count",     32'(count),     0);
    check("rst_lap_level", 32'(lap_level), 0);
    compare_all();
    rst_n = 1'b1;
    idle(2);

    // Start and first ticks.
    cycle(1, 0, 0, 0, 0);
    check("t1_status", 32'(status), 1);
    check("t1_count0", 32'(count),  0);
    idle(3);
    check("t1_count1", 32'(count),    1);
    check("t1_en",     32'(count_en), 1);
    idle(6);
    check("t1_count3", 32'(count), 3);

    // Pause/resume keeps prescaler phase.
    wait_count(5);
    cycle(0, 1, 0, 0, 0);
    idle(10);
    check("t2_status", 32'(status), 2);
    check("t2_hold",   32'(count),  5);
    cycle(1, 0, 0, 0, 0);
    idle(1);
    check("t2_resume5", 32'(count), 5);
    idle(1);
    check("t2_resume6", 32'(count), 6);

    // Top-of-range behaviour.
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    wait_count(15);
    idle(3);
`ifdef STOPWATCH_WRAP_EN
    check("t3_wrap_count",  32'(count),   0);
    check("t3_wrap_status", 32'(status),  1);
    check("t3_wrap_ovf",    32'(cnt_ovf), 1);
    idle(6);
    check("t3_wrap_sticky", 32'(cnt_ovf), 1);
    check("t3_wrap_run",    32'(count),   2);
`else
    check("t3_sat_status", 32'(status),  3);
    check("t3_sat_count",  32'(count),   15);
    check("t3_sat_ovf",    32'(cnt_ovf), 1);
    cycle(1, 0, 0, 0, 0);
    check("t3_sat_start", 32'(status), 3);
    cycle(0, 1, 0, 0, 0);
    check("t3_sat_stop",  32'(status), 3);
    idle(4);
    check("t3_sat_hold",  32'(count),  15);
`endif
    cycle(0, 0, 1, 0, 0);
    check("t3_clr_ovf",    32'(cnt_ovf), 0);
    check("t3_clr_status", 32'(status),  0);

    // Five laps without reads: one dropped.
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      wait_count(2 * k);
      cycle(0, 0, 0, 1, 0);
    end
    check("t4_level", 32'(lap_level), 4);
    check("t4_ovf",   32'(lap_ovf),   1);
    for (int k = 0; k < 4; k++) begin
      check("t4_pop", 32'(lap_data), 2 + 2 * k);
      cycle(0, 0, 0, 0, 1);
    end
    check("t4_empty", 32'(lap_valid), 0);
    cycle(0, 0, 0, 0, 1);

    // Full FIFO with simultaneous push and pop.
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      wait_count(k);
      cycle(0, 0, 0, 1, 0);
    end
    wait_count(5);
    check("t5_full", 32'(lap_level), 4);
    check("t5_head", 32'(lap_data),  1);
    cycle(0, 0, 0, 1, 1);
    check("t5_level", 32'(lap_level), 4);
    check("t5_adv",   32'(lap_data),  2);
    check("t5_ovf",   32'(lap_ovf),   0);
    for (int k = 0; k < 4; k++) cycle(0, 0, 0, 0, 1);
    check("t5_last_empty", 32'(lap_level), 0);

    // Reset beats lap/start; start+stop in idle holds.
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    wait_count(7);
    cycle(1, 0, 1, 1, 0);
    check("t6_status", 32'(status),    0);
    check("t6_count",  32'(count),     0);
    check("t6_valid",  32'(lap_valid), 0);
    cycle(1, 1, 0, 0, 0);
    check("t6_ss_idle", 32'(status), 0);
    idle(3);

    // Randomized pulses.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 5)  == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 99) == 0),
            ($urandom_range(0, 3)  == 0),
            ($urandom_range(0, 4)  == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
